umem_arbiter: RTL and testbench
===============================

Name: umem_arbiter

Overview:
- Two-port arbiter that lets the pipeline share one synchronous 4K-word unified memory (1-cycle read latency) between instruction fetch (IF port) and data access (Me port).
- Grants at most one access per cycle and returns a registered acknowledge one cycle later.
- The pipeline uses the inverted acks as per-stage stall / clock-enable.
- A starvation counter guarantees fetch progress when data traffic runs back-to-back.

Parameters:
- ADDR_W, 12, word address width.
- DATA_W, 32, data width.
- MAX_WAIT, 4, consecutive IF-denied cycles before IF is forced to win; legal range 1..15.

Ports:
- w_clk  in  1  clock, rising edge.
- w_rst  in  1  reset, asynchronous, active-high.
- w_if_req  in  1  fetch request, held until ack.
- w_if_addr  in  ADDR_W  fetch word address.
- w_if_ack  out  1  fetch done; w_if_rdata valid this cycle.
- w_if_rdata  out  DATA_W  fetch data.
- w_me_req  in  1  data request, held until ack.
- w_me_we  in  1  1 = store, 0 = load.
- w_me_addr  in  ADDR_W  data word address.
- w_me_wdata  in  DATA_W  store data.
- w_me_ack  out  1  data access done.
- w_me_rdata  out  DATA_W  load data.
- w_mem_addr  out  ADDR_W  memory address.
- w_mem_we  out  1  memory write enable.
- w_mem_wdata  out  DATA_W  memory write data.
- w_mem_rdata  in  DATA_W  memory read data, registered by the memory (valid cycle after address).

Behaviour:
- Reset (async, w_rst=1): w_if_ack=0, w_me_ack=0, wait counter=0, internal grant registers cleared. While reset is held, w_mem_we=0 and w_mem_addr=0. Reset mid-access drops the pending ack; the requester must re-request.
- Grant (combinational, cycle N):
  - Only one requester active: it wins.
  - Both active: Me wins, unless wait counter == MAX_WAIT, in which case IF wins.
- Memory drive in cycle N:
  - w_mem_addr = winner's address (0 when no grant).
  - w_mem_we = Me granted & w_me_we.
  - w_mem_wdata = w_me_wdata at all times.
- Ack: registered. Granted port's ack = 1 in cycle N+1 for exactly one cycle, for loads and stores alike. Latency is 1 cycle uncontended.
- Read data: w_if_rdata = w_me_rdata = w_mem_rdata continuously. Valid for a port only in that port's ack cycle.
- Back-to-back: a req still high in the ack cycle is a new request and may be granted in that same cycle. Maximum throughput is 1 access per cycle.
- Wait counter:
  - +1 each cycle IF requests and is not granted.
  - Cleared when IF is granted or w_if_req=0.
  - Saturates at MAX_WAIT.
- States (encoded by grant registers): IDLE (no ack pending), IF_PEND, ME_PEND. Next state is derived from the cycle-N grant; there is no multi-cycle hold.
- A write and a read to the same address in consecutive grants behave read-after-write correctly, because the memory writes at edge N and reads at edge N+1.
- No request is ever granted twice; no grant occurs when its req=0.

Optional Feature:
- Macro: UMEM_ARB_STATS_EN.
- Defined: adds outputs w_if_grants[31:0], w_me_grants[31:0], w_conflicts[31:0].
  - Counts IF grants, Me grants, and cycles with both reqs high, respectively.
  - Cleared by w_rst; wrap at 2^32.
  - Forced-IF grants count as both an IF grant and a conflict.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset mid-access: assert w_rst while an ack is pending -> ack never appears, counter=0, w_mem_we=0 while reset is held.
- Only IF requesting, addrs 0,1,2 held 1 cycle each -> w_if_ack high cycles 2,3,4; w_if_rdata = preloaded mem[0..2].
- Store 0xDEADBEEF to 0x010, then load 0x010 back-to-back -> w_mem_we=1 one cycle, second w_me_ack with w_me_rdata=0xDEADBEEF.
- Both req continuous, MAX_WAIT=4 -> grant pattern Me,Me,Me,Me,IF repeating; IF ack every 5th cycle.
- Both req in one cycle, then Me drops -> Me granted first, IF granted next cycle, wait counter returns to 0.
- With UMEM_ARB_STATS_EN: 10 cycles both req continuous, MAX_WAIT=4 -> w_me_grants=8, w_if_grants=2, w_conflicts=10.

Source files
------------

// File: rtl/umem_arbiter_if.sv
// Bus bundle between the pipeline ports, the arbiter and the unified memory.
// The slave modport is the arbiter's view. The master modport is the pipeline/memory side.
interface umem_arbiter_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
);
   logic              w_if_req;
   logic [ADDR_W-1:0] w_if_addr;
   logic              w_if_ack;
   logic [DATA_W-1:0] w_if_rdata;

   logic              w_me_req;
   logic              w_me_we;
   logic [ADDR_W-1:0] w_me_addr;
   logic [DATA_W-1:0] w_me_wdata;
   logic              w_me_ack;
   logic [DATA_W-1:0] w_me_rdata;

   logic [ADDR_W-1:0] w_mem_addr;
   logic              w_mem_we;
   logic [DATA_W-1:0] w_mem_wdata;
   logic [DATA_W-1:0] w_mem_rdata;

   modport slave (
      input  w_if_req, w_if_addr, w_me_req, w_me_we, w_me_addr, w_me_wdata, w_mem_rdata,
      output w_if_ack, w_if_rdata, w_me_ack, w_me_rdata, w_mem_addr, w_mem_we, w_mem_wdata
   );

   modport master (
      output w_if_req, w_if_addr, w_me_req, w_me_we, w_me_addr, w_me_wdata, w_mem_rdata,
      input  w_if_ack, w_if_rdata, w_me_ack, w_me_rdata, w_mem_addr, w_mem_we, w_mem_wdata
   );
endinterface

// File: rtl/umem_arbiter.sv
// Fetch/data arbiter for a shared 1-cycle-latency unified memory, with a fetch starvation guard.
// Optional grant/conflict counters are enabled with `define UMEM_ARB_STATS_EN.
//
// state   | meaning
// IDLE    | no ack due this cycle
// IF_PEND | fetch granted last cycle, w_if_ack high now
// ME_PEND | data access granted last cycle, w_me_ack high now
module umem_arbiter #(
   parameter int ADDR_W   = 12,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 4
) (
   input  logic w_clk,
   input  logic w_rst,
   umem_arbiter_if.slave bus
`ifdef UMEM_ARB_STATS_EN
   ,
   output logic [31:0] w_if_grants,
   output logic [31:0] w_me_grants,
   output logic [31:0] w_conflicts
`endif
);
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      IF_PEND = 2'd1,
      ME_PEND = 2'd2
   } state_t;

   state_t     state, state_nxt;
   logic [3:0] wait_cnt, wait_cnt_nxt;
   logic       grant_if, grant_me;

   always_ff @(posedge w_clk or posedge w_rst) begin
      if (w_rst) begin
         state    <= IDLE;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
      end
   end

   always_comb begin
      grant_if     = 1'b0;
      grant_me     = 1'b0;
      state_nxt    = IDLE;
      wait_cnt_nxt = wait_cnt;

      // Data wins contention until fetch has been denied MAX_WAIT cycles in a row.
      if (bus.w_if_req && bus.w_me_req) begin
         if (wait_cnt == 4'(MAX_WAIT)) grant_if = 1'b1;
         else                          grant_me = 1'b1;
      end else if (bus.w_if_req) begin
         grant_if = 1'b1;
      end else if (bus.w_me_req) begin
         grant_me = 1'b1;
      end

      if (grant_if)      state_nxt = IF_PEND;
      else if (grant_me) state_nxt = ME_PEND;

      if (!bus.w_if_req || grant_if)     wait_cnt_nxt = '0;
      else if (wait_cnt != 4'(MAX_WAIT)) wait_cnt_nxt = wait_cnt + 4'd1;
   end

   // Gate the memory drive with reset so a held reset never writes.
   assign bus.w_mem_addr  = w_rst    ? '0 :
                            grant_if ? bus.w_if_addr :
                            grant_me ? bus.w_me_addr : '0;
   assign bus.w_mem_we    = !w_rst && grant_me && bus.w_me_we;
   assign bus.w_mem_wdata = bus.w_me_wdata;

   assign bus.w_if_ack   = (state == IF_PEND);
   assign bus.w_me_ack   = (state == ME_PEND);
   assign bus.w_if_rdata = bus.w_mem_rdata;
   assign bus.w_me_rdata = bus.w_mem_rdata;

`ifdef UMEM_ARB_STATS_EN
   always_ff @(posedge w_clk or posedge w_rst) begin
      if (w_rst) begin
         w_if_grants <= '0;
         w_me_grants <= '0;
         w_conflicts <= '0;
      end else begin
         if (grant_if)                     w_if_grants <= w_if_grants + 32'd1;
         if (grant_me)                     w_me_grants <= w_me_grants + 32'd1;
         if (bus.w_if_req && bus.w_me_req) w_conflicts <= w_conflicts + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_umem_arbiter.sv
// Self-checking bench for umem_arbiter: directed scenarios plus randomized
// request traffic checked against a behavioural arbitration and memory model.
module tb_umem_arbiter;
   localparam int ADDR_W   = 12;
   localparam int DATA_W   = 32;
   localparam int MAX_WAIT = 4;
   localparam int DEPTH    = 1 << ADDR_W;

   logic w_clk;
   logic w_rst;

   umem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef UMEM_ARB_STATS_EN
   logic [31:0] if_grants, me_grants, conflicts;
`endif

   umem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
      .w_clk (w_clk),
      .w_rst (w_rst),
      .bus   (bus)
`ifdef UMEM_ARB_STATS_EN
      ,
      .w_if_grants (if_grants),
      .w_me_grants (me_grants),
      .w_conflicts (conflicts)
`endif
   );

   initial w_clk = 1'b0;
   always #5 w_clk = ~w_clk;

   // Synchronous memory: write at the edge, registered read data.
   logic [DATA_W-1:0] mem [DEPTH];
   always @(posedge w_clk) begin
      if (bus.w_mem_we) mem[bus.w_mem_addr] <= bus.w_mem_wdata;
      bus.w_mem_rdata <= mem[bus.w_mem_addr];
   end

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state
   logic [DATA_W-1:0] mmem [DEPTH];
   int                denied;
   bit                exp_if_ack, exp_me_ack, exp_me_load;
   logic [DATA_W-1:0] exp_rd;
   int                m_if, m_me, m_conf;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      denied      = 0;
      exp_if_ack  = 0;
      exp_me_ack  = 0;
      exp_me_load = 0;
      m_if        = 0;
      m_me        = 0;
      m_conf      = 0;
   endtask

   // Inputs are driven just after a falling edge; this checks the grant,
   // crosses one rising edge, and checks the ack/read data at the next falling edge.
   task automatic run_cycle();
      bit          g_if, g_me;
      logic [31:0] exp_addr;
      #1;
      g_if = 0;
      g_me = 0;
      if (bus.w_if_req && bus.w_me_req) begin
         if (denied >= MAX_WAIT) g_if = 1;
         else                    g_me = 1;
      end else begin
         g_if = bus.w_if_req;
         g_me = bus.w_me_req;
      end
      exp_addr = g_if ? 32'(bus.w_if_addr) : g_me ? 32'(bus.w_me_addr) : 32'd0;
      chk("mem_we", 32'(bus.w_mem_we), 32'(g_me && bus.w_me_we));
      chk("mem_addr", 32'(bus.w_mem_addr), exp_addr);
      if (g_me && bus.w_me_we) chk("mem_wdata", bus.w_mem_wdata, bus.w_me_wdata);

      if (g_if) m_if++;
      if (g_me) m_me++;
      if (bus.w_if_req && bus.w_me_req) m_conf++;

      exp_rd = 'x;
      if (g_if)                     exp_rd = mmem[bus.w_if_addr];
      else if (g_me && !bus.w_me_we) exp_rd = mmem[bus.w_me_addr];
      if (g_me && bus.w_me_we) mmem[bus.w_me_addr] = bus.w_me_wdata;

      if (bus.w_if_req && !g_if) denied = (denied + 1 > MAX_WAIT) ? MAX_WAIT : denied + 1;
      else                       denied = 0;

      exp_if_ack  = g_if;
      exp_me_ack  = g_me;
      exp_me_load = g_me && !bus.w_me_we;

      @(negedge w_clk);
      chk("if_ack", 32'(bus.w_if_ack), 32'(exp_if_ack));
      chk("me_ack", 32'(bus.w_me_ack), 32'(exp_me_ack));
      if (exp_if_ack)  chk("if_rdata", bus.w_if_rdata, exp_rd);
      if (exp_me_load) chk("me_rdata", bus.w_me_rdata, exp_rd);
   endtask

   task automatic drive_idle();
      bus.w_if_req   = 0;
      bus.w_if_addr  = '0;
      bus.w_me_req   = 0;
      bus.w_me_we    = 0;
      bus.w_me_addr  = '0;
      bus.w_me_wdata = '0;
   endtask

   int  if_ack_seen;
   bit  if_busy, me_busy;

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         mem[i]  = $urandom;
         mmem[i] = mem[i];
      end
      drive_idle();
      w_rst = 1;
      model_reset();
      repeat (2) @(negedge w_clk);
      chk("rst_if_ack", 32'(bus.w_if_ack), 32'd0);
      chk("rst_me_ack", 32'(bus.w_me_ack), 32'd0);
      chk("rst_mem_we", 32'(bus.w_mem_we), 32'd0);
      chk("rst_mem_addr", 32'(bus.w_mem_addr), 32'd0);
      w_rst = 0;

      // Reset arrives while a store is being granted: the ack must never appear.
      bus.w_if_req   = 1;
      bus.w_if_addr  = 12'h005;
      bus.w_me_req   = 1;
      bus.w_me_we    = 1;
      bus.w_me_addr  = 12'h007;
      bus.w_me_wdata = 32'h1234_5678;
      #1;
      chk("pre_rst_mem_we", 32'(bus.w_mem_we), 32'd1);
      w_rst = 1;
      #1;
      chk("midrst_mem_we", 32'(bus.w_mem_we), 32'd0);
      chk("midrst_mem_addr", 32'(bus.w_mem_addr), 32'd0);
      @(negedge w_clk);
      chk("midrst_if_ack", 32'(bus.w_if_ack), 32'd0);
      chk("midrst_me_ack", 32'(bus.w_me_ack), 32'd0);
      chk("midrst_mem_we2", 32'(bus.w_mem_we), 32'd0);
      drive_idle();
      w_rst = 0;
      model_reset();
      run_cycle();

      // Sustained contention: four data grants then one fetch grant, repeating.
      bus.w_if_req   = 1;
      bus.w_if_addr  = 12'h020;
      bus.w_me_req   = 1;
      bus.w_me_we    = 0;
      bus.w_me_addr  = 12'h030;
      if_ack_seen    = 0;
      for (int c = 0; c < 10; c++) begin
         run_cycle();
         if (bus.w_if_ack) if_ack_seen++;
      end
      chk("contend_if_acks", 32'(if_ack_seen), 32'd2);
`ifdef UMEM_ARB_STATS_EN
      chk("stat_me_grants", me_grants, 32'd8);
      chk("stat_if_grants", if_grants, 32'd2);
      chk("stat_conflicts", conflicts, 32'd10);
`endif
      drive_idle();
      run_cycle();

      // Fetch-only stream, one address per cycle.
      for (int a = 0; a < 3; a++) begin
         bus.w_if_req  = 1;
         bus.w_if_addr = 12'(a);
         run_cycle();
      end
      drive_idle();
      run_cycle();

      // Store then load of the same word back-to-back.
      bus.w_me_req   = 1;
      bus.w_me_we    = 1;
      bus.w_me_addr  = 12'h010;
      bus.w_me_wdata = 32'hDEAD_BEEF;
      run_cycle();
      bus.w_me_we    = 0;
      run_cycle();
      chk("raw_rdata", bus.w_me_rdata, 32'hDEAD_BEEF);
      drive_idle();
      run_cycle();

      // Contention, then data drops: fetch must win the following cycle.
      bus.w_if_req  = 1;
      bus.w_if_addr = 12'h040;
      bus.w_me_req  = 1;
      bus.w_me_addr = 12'h041;
      run_cycle();
      bus.w_me_req  = 0;
      run_cycle();
      bus.w_if_req  = 0;
      run_cycle();

      // Randomized traffic: each port holds its request until acknowledged.
      if_busy = 0;
      me_busy = 0;
      for (int c = 0; c < 3000; c++) begin
         if (exp_if_ack) if_busy = 0;
         if (exp_me_ack) me_busy = 0;
         if (!if_busy && $urandom_range(99) < 60) begin
            if_busy       = 1;
            bus.w_if_addr = 12'($urandom_range(15));
         end
         if (!me_busy && $urandom_range(99) < 60) begin
            me_busy        = 1;
            bus.w_me_we    = $urandom_range(1) == 1;
            bus.w_me_addr  = 12'($urandom_range(15));
            bus.w_me_wdata = $urandom;
         end
         bus.w_if_req = if_busy;
         bus.w_me_req = me_busy;
         run_cycle();
      end
      drive_idle();
      run_cycle();
`ifdef UMEM_ARB_STATS_EN
      chk("stat_if_final", if_grants, 32'(m_if));
      chk("stat_me_final", me_grants, 32'(m_me));
      chk("stat_conf_final", conflicts, 32'(m_conf));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
